pdm_mic_ctrl: RTL and testbench
===============================

PDM_MIC_CTRL -- requirements
Module: pdm_mic_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- CLK_FREQ, 44, system clock in MHz.
- SAMPLE_RATE, 2750000, PDM bit rate in Hz.
- DEC_RATE, 80, PDM bits per channel per decimated output.
- SETTLE, 64, m_clk periods after enable before bits are forwarded.
- DISCARD, 3, decimated outputs per channel dropped after settle (sinc3 warm-up).
REQ-002 Local constant CLK_COUNT SHALL be (CLK_FREQ*1000000)/(SAMPLE_RATE*2), default 8; one m_clk period is 2*CLK_COUNT clk cycles.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  system clock; the block uses this one clock only.
- reset_n  in  1  synchronous reset, active-low.
- enable  in  1  level; 1 requests capture.
- stereo  in  1  1 = L and R; 0 = L only. Sampled in IDLE only.
- m_clk  out  1  microphone clock.
- m_data  in  1  PDM data from the microphone(s).
- l_bit, r_bit  out  1  captured PDM bits for the left and right filter channels.
- l_en, r_en  out  1  1-clk strobes qualifying l_bit and r_bit.
- dec_en  out  1  1-clk strobe commanding both filters to run the comb stage.
- l_data, r_data  in  8  filter outputs.
- l_valid, r_valid  in  1  1-clk strobes qualifying l_data and r_data.
- out_data  out  8  output sample.
- out_ch  out  1  0 = left, 1 = right.
- out_valid  out  1  output handshake valid.
- out_ready  in  1  output handshake ready.
- overflow  out  1  sticky; set when a sample is dropped.
- busy  out  1  state != IDLE.

Function
REQ-004 FSM states SHALL be IDLE, SETTLE, WARMUP, RUN and STOP.
REQ-005 IDLE: m_clk=0 and the phase counter is held at 0. enable=1 SHALL latch stereo and go to SETTLE on the next clk.
REQ-006 Outside IDLE, a phase counter SHALL count 0..CLK_COUNT-1. At CLK_COUNT-1 it wraps and m_clk toggles.
REQ-007 Capture at phase CLK_COUNT-1:
- m_clk=1 (falling edge next): m_data is the left bit.
- m_clk=0 (rising edge next): m_data is the right bit.
REQ-008 The captured bit SHALL appear on l_bit or r_bit with l_en or r_en high exactly 1 clk later. r_en SHALL never assert when stereo=0.
REQ-009 SETTLE: count SETTLE complete m_clk periods with l_en and r_en suppressed, then go to WARMUP.
REQ-010 In WARMUP and RUN, a decimation counter SHALL count emitted l_en pulses modulo DEC_RATE. dec_en SHALL pulse on the clk after the l_en that makes the count reach DEC_RATE-1.
REQ-011 WARMUP SHALL ignore l_valid and r_valid. After DISCARD dec_en pulses it goes to RUN.
REQ-012 RUN SHALL keep one holding register per channel.
- l_valid or r_valid with its register empty: load the register.
- Register full: drop the new sample and set overflow.
REQ-013 Output arbitration:
- Left register has priority over right.
- out_data, out_ch and out_valid SHALL be registered and stable while out_valid=1 and out_ready=0.
- Transfer occurs on out_valid and out_ready both high; out_valid may reassert on the next clk.
REQ-014 Latency from l_valid into an empty path, with out_ready=1, to out_valid SHALL be 2 clk.
REQ-015 enable=0 in SETTLE, WARMUP or RUN SHALL go to STOP.
REQ-016 STOP behaviour:
- Suppress l_en, r_en and dec_en.
- Continue m_clk until the next falling edge leaves m_clk=0.
- Then go to IDLE.
- Buffered samples SHALL still drain, including from IDLE.
REQ-017 enable reasserted during STOP SHALL take effect only after IDLE is reached.
REQ-018 overflow SHALL be cleared only by reset or by the IDLE->SETTLE transition.
REQ-019 If l_valid and r_valid arrive on the same clk, both registers SHALL load (subject to REQ-012).

Reset
REQ-020 reset_n=0 sampled on a clk edge SHALL force the state to IDLE and clear all counters and both holding registers.
REQ-021 Reset values of outputs:
- m_clk, l_bit, r_bit, l_en, r_en, dec_en, out_valid, overflow and busy = 0.
- out_data = 0, out_ch = 0.
REQ-022 Reset applied mid-operation SHALL take effect on that edge without completing the m_clk period.

Verification
REQ-023 Defaults with enable=1 and stereo=1:
- The first m_clk rise is 8 clk after leaving IDLE, and the period is 16 clk.
- The first l_en follows 64 periods plus one falling edge.
REQ-024 m_data=1 at a left capture and 0 at a right capture SHALL give l_bit=1 then r_bit=0, each with a 1-clk strobe.
REQ-025 Counting l_en pulses: dec_en fires every 80 l_en. The first 3 dec_en periods' l_valid are ignored, and the 4th period's l_data=0x5A appears as out_data=0x5A, out_ch=0, 2 clk later.
REQ-026 out_ready=0 with two l_valid pulses in RUN: the first is held stable, the second is dropped, and overflow=1 until the next IDLE->SETTLE.
REQ-027 Same-clk l_valid=0x11 and r_valid=0x22 with out_ready=1: outputs are 0x11 (ch0) then 0x22 (ch1) on consecutive transfers.
REQ-028 enable=0 while m_clk=1: m_clk falls at the phase wrap, then stays 0 and busy=0. reset_n=0 mid-RUN: all outputs are 0 on the next clk.

Source files
------------

// File: rtl/pdm_mic_ctrl.sv
// PDM microphone front end: generates m_clk, splits L/R bits toward the sinc
// filters, paces decimation and arbitrates the filter outputs onto one stream.
//
// state     | meaning
// ST_IDLE   | m_clk parked low, waiting for enable
// ST_SETTLE | m_clk running, mic settling, no bits forwarded
// ST_WARMUP | bits forwarded, filter outputs discarded
// ST_RUN    | filter outputs buffered and streamed out
// ST_STOP   | finishing the m_clk period, then back to idle
module pdm_mic_ctrl #(
   parameter int CLK_FREQ    = 44,
   parameter int SAMPLE_RATE = 2750000,
   parameter int DEC_RATE    = 80,
   parameter int SETTLE      = 64,
   parameter int DISCARD     = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       stereo,
   output logic       m_clk,
   input  logic       m_data,
   output logic       l_bit,
   output logic       r_bit,
   output logic       l_en,
   output logic       r_en,
   output logic       dec_en,
   input  logic [7:0] l_data,
   input  logic [7:0] r_data,
   input  logic       l_valid,
   input  logic       r_valid,
   output logic [7:0] out_data,
   output logic       out_ch,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       overflow,
   output logic       busy
);

   localparam int CLK_COUNT = (CLK_FREQ * 1000000) / (SAMPLE_RATE * 2);
   localparam int PH_W  = (CLK_COUNT > 1) ? $clog2(CLK_COUNT) : 1;
   localparam int DEC_W = (DEC_RATE > 1) ? $clog2(DEC_RATE) : 1;
   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int DSC_W = (DISCARD > 1) ? $clog2(DISCARD) : 1;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_COUNT - 1);
   localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DEC_RATE - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
   localparam logic [DSC_W-1:0] DSC_LAST = DSC_W'(DISCARD - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_WARMUP,
      ST_RUN,
      ST_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
   logic [DSC_W-1:0]  disc_cnt_q, disc_cnt_d;
   logic              m_clk_q, m_clk_d;
   logic              stereo_q, stereo_d;
   logic              l_bit_q, l_bit_d, r_bit_q, r_bit_d;
   logic              l_en_q, l_en_d, r_en_q, r_en_d, dec_en_q, dec_en_d;
   logic [7:0]        l_hold_q, l_hold_d, r_hold_q, r_hold_d;
   logic              l_full_q, l_full_d, r_full_q, r_full_d;
   logic [7:0]        out_data_q, out_data_d;
   logic              out_ch_q, out_ch_d, out_valid_q, out_valid_d;
   logic              overflow_q, overflow_d, busy_q, busy_d;

   logic   wrap, fall, streaming;
   state_t stop_next;

   assign wrap      = (state_q != ST_IDLE) && (phase_q == PH_LAST);
   assign fall      = wrap && m_clk_q;
   assign streaming = ((state_q == ST_WARMUP) || (state_q == ST_RUN)) && enable;
   // A stop request landing on a falling edge can go straight to idle.
   assign stop_next = fall ? ST_IDLE : ST_STOP;

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      settle_cnt_d = settle_cnt_q;
      dec_cnt_d    = dec_cnt_q;
      disc_cnt_d   = disc_cnt_q;
      m_clk_d      = m_clk_q;
      stereo_d     = stereo_q;
      l_bit_d      = l_bit_q;
      r_bit_d      = r_bit_q;
      l_en_d       = 1'b0;
      r_en_d       = 1'b0;
      dec_en_d     = 1'b0;
      l_hold_d     = l_hold_q;
      r_hold_d     = r_hold_q;
      l_full_d     = l_full_q;
      r_full_d     = r_full_q;
      out_data_d   = out_data_q;
      out_ch_d     = out_ch_q;
      out_valid_d  = out_valid_q;
      overflow_d   = overflow_q;

      if (state_q == ST_IDLE) begin
         phase_d = '0;
         m_clk_d = 1'b0;
      end else begin
         phase_d = wrap ? '0 : phase_q + 1'b1;
         if (wrap) m_clk_d = ~m_clk_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d      = ST_SETTLE;
               stereo_d     = stereo;
               overflow_d   = 1'b0;
               settle_cnt_d = '0;
               dec_cnt_d    = '0;
               disc_cnt_d   = '0;
            end
         end
         ST_SETTLE: begin
            if (!enable) begin
               state_d = stop_next;
            end else if (fall) begin
               if (settle_cnt_q == SET_LAST) begin
                  state_d      = ST_WARMUP;
                  settle_cnt_d = '0;
               end else begin
                  settle_cnt_d = settle_cnt_q + 1'b1;
               end
            end
         end
         ST_WARMUP: begin
            if (!enable) begin
               state_d = stop_next;
            end else if (dec_en_q) begin
               if (disc_cnt_q == DSC_LAST) state_d = ST_RUN;
               else disc_cnt_d = disc_cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (!enable) state_d = stop_next;
         end
         ST_STOP: begin
            if (fall) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Left bit is valid just before the falling edge, right bit before the rising one.
      if (wrap && streaming) begin
         if (m_clk_q) begin
            l_bit_d = m_data;
            l_en_d  = 1'b1;
         end else if (stereo_q) begin
            r_bit_d = m_data;
            r_en_d  = 1'b1;
         end
      end

      if (streaming && l_en_q) begin
         if (dec_cnt_q == DEC_LAST) begin
            dec_cnt_d = '0;
            dec_en_d  = 1'b1;
         end else begin
            dec_cnt_d = dec_cnt_q + 1'b1;
         end
      end

      if (!out_valid_q || out_ready) begin
         out_valid_d = 1'b0;
         if (l_full_q) begin
            out_data_d  = l_hold_q;
            out_ch_d    = 1'b0;
            out_valid_d = 1'b1;
            l_full_d    = 1'b0;
         end else if (r_full_q) begin
            out_data_d  = r_hold_q;
            out_ch_d    = 1'b1;
            out_valid_d = 1'b1;
            r_full_d    = 1'b0;
         end
      end

      // A full register drops the newcomer even if it is draining this cycle.
      if (state_q == ST_RUN) begin
         if (l_valid) begin
            if (l_full_q) begin
               overflow_d = 1'b1;
            end else begin
               l_hold_d = l_data;
               l_full_d = 1'b1;
            end
         end
         if (r_valid) begin
            if (r_full_q) begin
               overflow_d = 1'b1;
            end else begin
               r_hold_d = r_data;
               r_full_d = 1'b1;
            end
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         settle_cnt_q <= '0;
         dec_cnt_q    <= '0;
         disc_cnt_q   <= '0;
         m_clk_q      <= 1'b0;
         stereo_q     <= 1'b0;
         l_bit_q      <= 1'b0;
         r_bit_q      <= 1'b0;
         l_en_q       <= 1'b0;
         r_en_q       <= 1'b0;
         dec_en_q     <= 1'b0;
         l_hold_q     <= '0;
         r_hold_q     <= '0;
         l_full_q     <= 1'b0;
         r_full_q     <= 1'b0;
         out_data_q   <= '0;
         out_ch_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         overflow_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         settle_cnt_q <= settle_cnt_d;
         dec_cnt_q    <= dec_cnt_d;
         disc_cnt_q   <= disc_cnt_d;
         m_clk_q      <= m_clk_d;
         stereo_q     <= stereo_d;
         l_bit_q      <= l_bit_d;
         r_bit_q      <= r_bit_d;
         l_en_q       <= l_en_d;
         r_en_q       <= r_en_d;
         dec_en_q     <= dec_en_d;
         l_hold_q     <= l_hold_d;
         r_hold_q     <= r_hold_d;
         l_full_q     <= l_full_d;
         r_full_q     <= r_full_d;
         out_data_q   <= out_data_d;
         out_ch_q     <= out_ch_d;
         out_valid_q  <= out_valid_d;
         overflow_q   <= overflow_d;
         busy_q       <= busy_d;
      end
   end

   assign m_clk     = m_clk_q;
   assign l_bit     = l_bit_q;
   assign r_bit     = r_bit_q;
   assign l_en      = l_en_q;
   assign r_en      = r_en_q;
   assign dec_en    = dec_en_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Directed bench for pdm_mic_ctrl: start-up timing, bit steering, decimation
// pacing, output buffering via a per-cycle vector table, stop and reset.
module tb_pdm_mic_ctrl;

   logic       clk = 1'b0;
   logic       reset_n, enable, stereo, out_ready, l_valid, r_valid;
   logic [7:0] l_data, r_data;
   logic       m_data;
   logic       m_clk, l_bit, r_bit, l_en, r_en, dec_en, out_ch, out_valid, overflow, busy;
   logic [7:0] out_data;
   logic [17:0] outs_vec;

   always #5 clk = ~clk;

   // Mic model: drives 1 while m_clk is high (left slot) and 0 while low (right slot).
   assign m_data   = m_clk;
   assign outs_vec = {m_clk, l_bit, r_bit, l_en, r_en, dec_en, out_valid, overflow,
                      busy, out_ch, out_data};

   pdm_mic_ctrl dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .stereo(stereo),
      .m_clk(m_clk), .m_data(m_data), .l_bit(l_bit), .r_bit(r_bit),
      .l_en(l_en), .r_en(r_en), .dec_en(dec_en),
      .l_data(l_data), .r_data(r_data), .l_valid(l_valid), .r_valid(r_valid),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready), .overflow(overflow), .busy(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int t0 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   int first_len = -1;
   int first_ren = -1;
   int ren_cnt = 0;
   int bit_err = 0;
   int len_since_dec = 0;
   int dec_gap[$];

   always @(negedge clk) begin
      if (l_en) begin
         len_since_dec++;
         if (first_len < 0) first_len = cyc - t0;
         if (l_bit !== 1'b1) bit_err++;
      end
      if (r_en) begin
         ren_cnt++;
         if (first_ren < 0) first_ren = cyc - t0;
         if (r_bit !== 1'b0) bit_err++;
      end
      if (dec_en) begin
         dec_gap.push_back(len_since_dec);
         len_since_dec = 0;
      end
   end

   typedef struct {
      logic       lv;
      logic [7:0] ld;
      logic       rv;
      logic [7:0] rd;
      logic       rdy;
      logic       ev;
      logic [7:0] ed;
      logic       ech;
      logic       eovf;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_mclk(input logic lvl, output int t);
      t = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (m_clk === lvl) begin
            t = cyc - t0;
            break;
         end
      end
   endtask

   task automatic wait_dec(output int t);
      t = -1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (dec_en === 1'b1) begin
            t = cyc - t0;
            break;
         end
      end
   endtask

   task automatic pulse_lr(input logic [7:0] d);
      l_valid = 1'b1; r_valid = 1'b1; l_data = d; r_data = d;
      @(negedge clk);
      l_valid = 1'b0; r_valid = 1'b0;
   endtask

   initial begin
      int   t, r1, r2, f1, d1, d2, d3, n, viol, rc, t1;
      logic prev, found;

      tbl[0]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 8'hA1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 8'hA2, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 8'hB1, 1'b1, 8'hB2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 8'h00, 1'b1, 8'hB3, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

      reset_n = 1'b0; enable = 1'b0; stereo = 1'b1; out_ready = 1'b1;
      l_valid = 1'b0; r_valid = 1'b0; l_data = 8'h00; r_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'(outs_vec), 32'h0);

      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_mclk", 32'(m_clk), 32'h0);

      enable = 1'b1;
      @(negedge clk);
      t0 = cyc;
      chk("busy_after_enable", 32'(busy), 32'h1);
      stereo = 1'b0;

      wait_mclk(1'b1, r1);
      chk("first_mclk_rise", 32'(r1), 32'd8);
      wait_mclk(1'b0, f1);
      chk("first_mclk_fall", 32'(f1), 32'd16);
      wait_mclk(1'b1, r2);
      chk("mclk_period", 32'(r2 - r1), 32'd16);

      while ((cyc - t0) < 1100) @(negedge clk);
      pulse_lr(8'hEE);
      wait_dec(d1);
      chk("first_l_en", 32'(first_len), 32'd1040);
      chk("first_r_en", 32'(first_ren), 32'd1032);
      chk("dec1_time", 32'(d1), 32'd2305);
      repeat (2) @(negedge clk);
      pulse_lr(8'hEE);
      wait_dec(d2);
      chk("dec_period", 32'(d2 - d1), 32'd1280);
      repeat (2) @(negedge clk);
      pulse_lr(8'hEE);
      wait_dec(d3);
      chk("dec3_time", 32'(d3), 32'd4865);
      repeat (3) @(negedge clk);
      chk("warmup_ignored_valid", 32'(out_valid), 32'h0);
      chk("warmup_no_overflow", 32'(overflow), 32'h0);
      chk("dec_gap_0", (dec_gap.size() > 0) ? 32'(dec_gap[0]) : 32'hFFFF, 32'd80);
      chk("dec_gap_2", (dec_gap.size() > 2) ? 32'(dec_gap[2]) : 32'hFFFF, 32'd80);
      chk("bit_steering_errors", 32'(bit_err), 32'h0);
      chk("stereo_latched_r_en", 32'(ren_cnt > 0), 32'h1);

      l_valid = 1'b1; l_data = 8'h5A; out_ready = 1'b1;
      @(negedge clk);
      l_valid = 1'b0;
      chk("lat_1clk_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      chk("lat_2clk_valid", 32'(out_valid), 32'h1);
      chk("lat_2clk_data", 32'(out_data), 32'h5A);
      chk("lat_2clk_ch", 32'(out_ch), 32'h0);
      @(negedge clk);
      chk("after_transfer_valid", 32'(out_valid), 32'h0);

      for (int i = 0; i < 15; i++) begin
         l_valid = tbl[i].lv; l_data = tbl[i].ld;
         r_valid = tbl[i].rv; r_data = tbl[i].rd;
         out_ready = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_ch", i), 32'(out_ch), 32'(tbl[i].ech));
         end
         chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].eovf));
      end
      l_valid = 1'b0; r_valid = 1'b0; out_ready = 1'b1;

      found = 1'b0;
      prev = m_clk;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!prev && m_clk) begin
            found = 1'b1;
            break;
         end
         prev = m_clk;
      end
      chk("stop_rise_found", 32'(found), 32'h1);
      enable = 1'b0;
      n = -1; viol = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (l_en || r_en || dec_en) viol++;
         if (!m_clk) begin
            n = k;
            break;
         end
      end
      chk("stop_fall_delay", 32'(n), 32'd8);
      chk("stop_busy_low", 32'(busy), 32'h0);
      repeat (40) begin
         @(negedge clk);
         if (m_clk || busy || l_en || r_en || dec_en) viol++;
      end
      chk("stop_idle_quiet", 32'(viol), 32'h0);
      chk("overflow_sticky", 32'(overflow), 32'h1);

      stereo = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      t1 = cyc;
      stereo = 1'b1;
      chk("restart_overflow_clear", 32'(overflow), 32'h0);
      chk("restart_busy", 32'(busy), 32'h1);
      n = -1; rc = 0;
      for (int k = 0; k < 1200; k++) begin
         @(negedge clk);
         if (r_en) rc++;
         if (l_en) begin
            n = cyc - t1;
            break;
         end
      end
      chk("mono_first_l_en", 32'(n), 32'd1040);
      chk("mono_no_r_en", 32'(rc), 32'h0);
      chk("mono_l_bit", 32'(l_bit), 32'h1);

      reset_n = 1'b0;
      @(negedge clk);
      chk("reset_mid_run", 32'(outs_vec), 32'h0);
      reset_n = 1'b1;
      enable = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
